// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch/jump opcodes, fetch defaults and fetch FSM states.
package cpu_pkg;

    localparam logic [5:0] JUMP = 6'b000010;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] BNE  = 6'b000001;
    localparam logic [5:0] BLT  = 6'b000011;
    localparam logic [5:0] BGE  = 6'b000101;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_ifid.sv
// IF/ID pipeline register: reset > flush > stall (hold) > load > bubble.
module ifid_pipeline_reg #(
    parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        stall_i,
    input  logic        load_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pcplus4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pcplus4_o,
    output logic        valid_o
);

    logic [31:0] instr_q;
    logic [31:0] pcplus4_q;
    logic        valid_q;

    // Update the IF/ID contents; flush and bubble leave pcplus4 untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q   <= NOP_INSTR;
            pcplus4_q <= '0;
            valid_q   <= 1'b0;
        end else if (flush_i) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (stall_i) begin
            instr_q   <= instr_q;
            pcplus4_q <= pcplus4_q;
            valid_q   <= valid_q;
        end else if (load_i) begin
            instr_q   <= instr_i;
            pcplus4_q <= pcplus4_i;
            valid_q   <= 1'b1;
        end else begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end
    end

    assign instr_o   = instr_q;
    assign pcplus4_o = pcplus4_q;
    assign valid_o   = valid_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: PC, single-outstanding instruction memory requests, hold buffer, IF/ID register.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = cpu_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pcsrc,
    input  logic [31:0] pc_addr,
    input  logic        IFID_flush,
    input  logic        IFID_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ID_instruction,
    output logic [31:0] ID_pcplus4,
    output logic        ID_valid
);

    import cpu_pkg::*;

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  hold_q;

    logic         redirect;
    logic         load;
    logic [31:0]  load_instr;
    logic [31:0]  pc_inc;

    assign pc_inc   = pc_q + 32'd4;
    assign redirect = pcsrc & ID_valid & ~IFID_stall;

    // The ISSUE state itself is the request cycle, so the pulse is decoded from the
    // state register; it is masked while rst is held so the port reads 0 in reset.
    assign imem_req  = (state_q == ISSUE) & ~rst;
    assign imem_addr = pc_q;

    // Select what, if anything, enters IF/ID this cycle.
    always_comb begin
        load       = 1'b0;
        load_instr = imem_rdata;
        case (state_q)
            WAIT: begin
                load = imem_rvalid & ~IFID_stall & ~redirect;
            end
            HOLD: begin
                load       = ~IFID_stall & ~redirect;
                load_instr = hold_q;
            end
            default: begin
                load = 1'b0;
            end
        endcase
    end

    // Fetch FSM with PC and hold buffer; a redirect always wins over a returning response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ISSUE;
            pc_q    <= RESET_PC;
            hold_q  <= '0;
        end else begin
            case (state_q)
                ISSUE: begin
                    state_q <= WAIT;
                    if (redirect) begin
                        pc_q    <= pc_addr;
                        state_q <= DRAIN;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        pc_q    <= pc_addr;
                        state_q <= imem_rvalid ? ISSUE : DRAIN;
                    end else if (imem_rvalid) begin
                        if (!IFID_stall) begin
                            pc_q    <= pc_inc;
                            state_q <= ISSUE;
                        end else begin
                            hold_q  <= imem_rdata;
                            state_q <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc_q    <= pc_addr;
                        state_q <= ISSUE;
                    end else if (!IFID_stall) begin
                        pc_q    <= pc_inc;
                        state_q <= ISSUE;
                    end
                end
                DRAIN: begin
                    if (redirect) begin
                        pc_q <= pc_addr;
                    end
                    if (imem_rvalid) begin
                        state_q <= ISSUE;
                    end
                end
                default: begin
                    state_q <= ISSUE;
                end
            endcase
        end
    end

    ifid_pipeline_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_ifid (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (IFID_flush),
        .stall_i   (IFID_stall),
        .load_i    (load),
        .instr_i   (load_instr),
        .pcplus4_i (pc_inc),
        .instr_o   (ID_instruction),
        .pcplus4_o (ID_pcplus4),
        .valid_o   (ID_valid)
    );

endmodule
